// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and byte constants for the SPI slave
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t;
  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_UNDERRUN_FILL = 8'hFF;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: synchronizes sclk/cs_n/mosi into clk and detects their edges
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_s,
  output logic mosi_s
);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d, armed;
  logic [FW-1:0] flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '1;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b1;
      cs_d   <= 1'b1;
      flush  <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
      flush  <= flush == FW'(SYNC_STAGES) ? flush : flush + FW'(1);
      // a select held low through reset is not a fresh edge: arm only once the chain has shown cs_n high
      armed  <= armed | (flush == FW'(SYNC_STAGES) && cs_q[SYNC_STAGES-1]);
    end
  end
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign cs_rise   = cs_s & ~cs_d;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-3 SPI target with a one-byte tx holding register
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);
  localparam int CW = $clog2(SPI_BYTE_W);
  spi_state_t state, nxt;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s, mosi_s;
  logic [SPI_BYTE_W-1:0] tx_shift, rx_shift, hold;
  logic [CW-1:0] cnt;
  logic hold_full, miso_q, byte_done, under_pend, load, shift_on, wr, last_rise;
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall),
    .cs_rise(cs_rise), .cs_s(cs_s), .mosi_s(mosi_s)
  );
  assign load      = state == LOAD;
  assign shift_on  = state == SHIFT && !cs_s;
  assign wr        = tx_valid && !hold_full;
  assign last_rise = sclk_rise && cnt == CW'(SPI_BYTE_W - 1);
  assign tx_ready  = !hold_full;
  assign busy      = !cs_s;
  assign miso_oe   = !cs_s;
  assign miso      = miso_q && !cs_s;
  always_comb begin
    nxt = cs_s ? IDLE : state == IDLE ? (cs_fall ? LOAD : IDLE) : load ? SHIFT : last_rise ? LOAD : SHIFT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      miso_q      <= 1'b0;
      byte_done   <= 1'b0;
      under_pend  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      hold_full   <= wr | (hold_full & ~load);
      if (wr) hold <= tx_data;
      byte_done   <= shift_on && last_rise;
      rx_valid    <= byte_done;
      if (byte_done) rx_data <= rx_shift;
      frame_abort <= cs_rise && cnt != '0;
      // the fill loaded after a frame's last byte is never shifted out, so report underrun on the byte's first edge
      tx_underrun <= shift_on && sclk_fall && under_pend;
      if (load) begin
        tx_shift   <= hold_full ? hold : SPI_UNDERRUN_FILL;
        under_pend <= !hold_full;
        cnt        <= '0;
      end else if (shift_on) begin
        if (sclk_fall) begin
          miso_q     <= tx_shift[SPI_BYTE_W-1];
          tx_shift   <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
          under_pend <= 1'b0;
        end
        if (sclk_rise) begin
          rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
          cnt      <= cnt + CW'(1);
        end
      end else if (state == IDLE) begin
        cnt    <= '0;
        miso_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized mode-3 frames checked against a byte-level model
module tb_spi_slave;
  logic clk = 1'b0, rst, sclk, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready;
  logic rx_valid, tx_underrun, frame_abort, busy;
  logic [7:0] tx_data, rx_data;
  logic [7:0] mo_a[4], tx_a[4], mi_a[4];
  bit we_a[4];
  logic [7:0] rx_q[$];
  int nc, nf, un_cnt, ab_cnt;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) un_cnt++;
    if (frame_abort) ab_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    nc++;
    if (t == 100) begin
      nf++;
      $display("FAIL write_wait: tx_ready=%b required 1", tx_ready);
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    nc++;
    if (tx_ready !== 1'b0) begin
      nf++;
      $display("FAIL ready_drop: tx_ready=%b required 0", tx_ready);
    end
  endtask

  task automatic run_frame(input int n, input int abort_bits, input int wr_at, input bit keep_cs);
    cs_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == wr_at) begin
        tx_data = tx_a[0];
        tx_valid = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
    end
    nc++;
    if ({busy, miso_oe} !== 2'b11) begin
      nf++;
      $display("FAIL busy_oe: busy,miso_oe=%b required 11", {busy, miso_oe});
    end
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (abort_bits > 0 && i >= abort_bits) break;
        sclk = 1'b0;
        mosi = mo_a[b][7-i];
        repeat (2) @(negedge clk);
        if (i == 0 && b + 1 < n && we_a[b+1]) begin
          tx_data = tx_a[b+1];
          tx_valid = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        mi_a[b][7-i] = miso;
        sclk = 1'b1;
        repeat (6) @(negedge clk);
      end
    end
    if (!keep_cs) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    nc++;
    if ({tx_ready, miso, miso_oe, rx_valid, tx_underrun, frame_abort, busy, rx_data} !== {1'b1, 14'b0}) begin
      nf++;
      $display("FAIL reset_outputs: got %b required %b",
               {tx_ready, miso, miso_oe, rx_valid, tx_underrun, frame_abort, busy, rx_data}, {1'b1, 14'b0});
    end
  endtask

  task automatic test_single;
    int u0;
    u0 = un_cnt;
    rx_q.delete();
    mo_a[0] = 8'h3C;
    we_a = '{0, 0, 0, 0};
    write_tx(8'hA5);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    run_frame(1, 0, -1, 0);
    nc++;
    if (mi_a[0] !== 8'hA5) begin nf++; $display("FAIL single_miso: got %h required a5", mi_a[0]); end
    nc++;
    if (rx_q.size() != 1 || rx_data !== 8'h3C) begin
      nf++;
      $display("FAIL single_rx: pulses=%0d rx_data=%h required 1 pulse of 3c", rx_q.size(), rx_data);
    end
    nc++;
    if (tx_ready !== 1'b1 || un_cnt != u0) begin
      nf++;
      $display("FAIL single_ready: tx_ready=%b underruns=%0d required 1 and 0", tx_ready, un_cnt - u0);
    end
  endtask

  task automatic test_multi;
    int u0;
    logic [7:0] exp_tx[3];
    u0 = un_cnt;
    rx_q.delete();
    exp_tx = '{8'h11, 8'h22, 8'h33};
    mo_a = '{8'h01, 8'h02, 8'h03, 8'h00};
    tx_a = '{8'h00, 8'h22, 8'h33, 8'h00};
    we_a = '{0, 1, 1, 0};
    write_tx(8'h11);
    run_frame(3, 0, -1, 0);
    nc++;
    if (rx_q.size() != 3) begin nf++; $display("FAIL multi_count: got %0d required 3", rx_q.size()); end
    for (int b = 0; b < 3; b++) begin
      nc++;
      if (mi_a[b] !== exp_tx[b] || rx_q[b] !== mo_a[b]) begin
        nf++;
        $display("FAIL multi_byte%0d: miso=%h rx=%h required %h and %h", b, mi_a[b], rx_q[b], exp_tx[b], mo_a[b]);
      end
    end
    nc++;
    if (un_cnt != u0) begin nf++; $display("FAIL multi_underrun: got %0d required 0", un_cnt - u0); end
  endtask

  task automatic test_underrun;
    int u0;
    u0 = un_cnt;
    rx_q.delete();
    mo_a[0] = 8'($urandom);
    we_a = '{0, 0, 0, 0};
    run_frame(1, 0, -1, 0);
    nc++;
    if (mi_a[0] !== 8'hFF || un_cnt != u0 + 1) begin
      nf++;
      $display("FAIL underrun: miso=%h pulses=%0d required ff and 1", mi_a[0], un_cnt - u0);
    end
    nc++;
    if (rx_q.size() != 1 || rx_q[0] !== mo_a[0]) begin
      nf++;
      $display("FAIL underrun_rx: pulses=%0d rx=%h required 1 of %h", rx_q.size(), rx_q[0], mo_a[0]);
    end
  endtask

  task automatic test_abort;
    int a0;
    logic [7:0] old, x;
    a0 = ab_cnt;
    old = rx_data;
    x = 8'($urandom);
    rx_q.delete();
    mo_a[0] = 8'($urandom);
    we_a = '{0, 0, 0, 0};
    write_tx(x);
    run_frame(1, 5, -1, 0);
    nc++;
    if (ab_cnt != a0 + 1 || rx_q.size() != 0 || rx_data !== old) begin
      nf++;
      $display("FAIL abort: aborts=%0d rx_pulses=%0d rx_data=%h required 1, 0, %h", ab_cnt - a0, rx_q.size(), rx_data, old);
    end
    nc++;
    if (mi_a[0][7:3] !== x[7:3]) begin nf++; $display("FAIL abort_miso: got %b required %b", mi_a[0][7:3], x[7:3]); end
    mo_a[0] = 8'($urandom);
    run_frame(1, 0, -1, 0);
    nc++;
    if (mi_a[0] !== 8'hFF || rx_q.size() != 1 || rx_q[0] !== mo_a[0] || ab_cnt != a0 + 1) begin
      nf++;
      $display("FAIL abort_next: miso=%h rx=%h pulses=%0d required ff, %h, 1", mi_a[0], rx_q[0], rx_q.size(), mo_a[0]);
    end
  endtask

  task automatic test_same_cycle;
    int u0;
    u0 = un_cnt;
    rx_q.delete();
    tx_a[0] = 8'($urandom_range(0, 254));
    mo_a[0] = 8'($urandom);
    mo_a[1] = 8'($urandom);
    we_a = '{0, 0, 0, 0};
    run_frame(2, 0, 3, 0);
    nc++;
    if (mi_a[0] !== 8'hFF || mi_a[1] !== tx_a[0] || un_cnt != u0 + 1) begin
      nf++;
      $display("FAIL same_cycle: miso=%h,%h underruns=%0d required ff,%h and 1", mi_a[0], mi_a[1], un_cnt - u0, tx_a[0]);
    end
    nc++;
    if (rx_q.size() != 2 || rx_q[0] !== mo_a[0] || rx_q[1] !== mo_a[1]) begin
      nf++;
      $display("FAIL same_cycle_rx: pulses=%0d required 2 of %h,%h", rx_q.size(), mo_a[0], mo_a[1]);
    end
  endtask

  task automatic test_reset_mid;
    int a0;
    a0 = ab_cnt;
    rx_q.delete();
    mo_a[0] = 8'($urandom);
    we_a = '{0, 0, 0, 0};
    write_tx(8'($urandom));
    run_frame(1, 4, -1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nc++;
    if ({tx_ready, miso, miso_oe, rx_valid, tx_underrun, frame_abort, busy, rx_data} !== {1'b1, 14'b0}) begin
      nf++;
      $display("FAIL reset_async: got %b required %b",
               {tx_ready, miso, miso_oe, rx_valid, tx_underrun, frame_abort, busy, rx_data}, {1'b1, 14'b0});
    end
    cs_n = 1'b1;
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    nc++;
    if (ab_cnt != a0 || rx_q.size() != 0) begin
      nf++;
      $display("FAIL reset_quiet: aborts=%0d rx_pulses=%0d required 0 and 0", ab_cnt - a0, rx_q.size());
    end
    tx_a[0] = 8'($urandom);
    mo_a[0] = 8'($urandom);
    write_tx(tx_a[0]);
    run_frame(1, 0, -1, 0);
    nc++;
    if (mi_a[0] !== tx_a[0] || rx_q.size() != 1 || rx_q[0] !== mo_a[0]) begin
      nf++;
      $display("FAIL reset_after: miso=%h rx=%h required %h and %h", mi_a[0], rx_q[0], tx_a[0], mo_a[0]);
    end
  endtask

  task automatic test_back_to_back;
    int n, u0;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(2, 4);
      u0 = un_cnt;
      rx_q.delete();
      for (int b = 0; b < 4; b++) begin
        mo_a[b] = 8'($urandom);
        tx_a[b] = 8'($urandom);
        we_a[b] = 1'b1;
      end
      write_tx(tx_a[0]);
      run_frame(n, 0, -1, 0);
      nc++;
      if (rx_q.size() != n || un_cnt != u0) begin
        nf++;
        $display("FAIL b2b_count: pulses=%0d underruns=%0d required %0d and 0", rx_q.size(), un_cnt - u0, n);
      end
      for (int b = 0; b < n; b++) begin
        nc++;
        if (mi_a[b] !== tx_a[b] || rx_q[b] !== mo_a[b]) begin
          nf++;
          $display("FAIL b2b_byte%0d: miso=%h rx=%h required %h and %h", b, mi_a[b], rx_q[b], tx_a[b], mo_a[b]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    test_reset;
    test_single;
    test_multi;
    test_underrun;
    test_abort;
    test_same_cycle;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi; legal values are 2 or more.
REQ-002 clk  input  1  system clock; one clock domain; clk SHALL be at least 4x the sclk frequency.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sclk  input  1  SPI clock from the initiator; idles high (mode 3).
REQ-005 cs_n  input  1  active-low chip select from the initiator.
REQ-006 mosi  input  1  serial data from the initiator, MSB first.
REQ-007 miso  output  1  serial data to the initiator, MSB first.
REQ-008 miso_oe  output  1  high while selected, used for the pad tristate.
REQ-009 tx_data  input  8  next byte to transmit.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  the tx holding register is empty.
REQ-012 rx_data  output  8  last complete received byte.
REQ-013 rx_valid  output  1  one-cycle pulse; rx_data has been updated.
REQ-014 tx_underrun  output  1  one-cycle pulse; a byte started while the holding register was empty.
REQ-015 frame_abort  output  1  one-cycle pulse; cs_n rose mid-byte.
REQ-016 busy  output  1  high while the synchronized cs_n is low.

Function
REQ-017 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flops; sclk edges SHALL be detected from the synchronized value and its one-cycle delay.
REQ-018 The FSM SHALL have states IDLE, LOAD and SHIFT.
- IDLE -> LOAD on synchronized cs_n falling.
- LOAD -> SHIFT after one cycle.
- SHIFT -> LOAD after the 8th rising edge while cs_n stays low.
- Any state -> IDLE on cs_n high.
REQ-019 LOAD SHALL copy the holding register into the tx shift register and mark the holding register empty.
- If the holding register is empty, LOAD SHALL load 8'hFF and pulse tx_underrun.
- The bit counter SHALL clear to 0.
REQ-020 In SHIFT, each synchronized sclk falling edge SHALL drive miso from tx_shift[7] and then shift tx_shift left.
- The MSB appears on the first falling edge of the byte.
REQ-021 In SHIFT, each synchronized sclk rising edge SHALL shift the synchronized mosi into the LSB of rx_shift and increment the 3-bit bit counter.
REQ-022 On the 8th rising edge, rx_data SHALL load the completed byte and rx_valid SHALL pulse on the next clk.
- Latency from the pin edge to rx_valid is SYNC_STAGES+2 clk.
REQ-023 Handshake: a transfer occurs when tx_valid and tx_ready are both high; tx_ready SHALL drop on the next clk and rise after the LOAD that consumes the byte.
REQ-024 If a write and a LOAD occur in the same cycle, LOAD SHALL see the holding register as empty (0xFF, underrun), and the written byte SHALL remain held for the next byte.
REQ-025 tx_valid while tx_ready is low SHALL be ignored; the holding register SHALL NOT be overwritten.
REQ-026 On cs_n rise with bit counter not 0, the block SHALL pulse frame_abort, discard the partial rx byte, leave rx_data unchanged and not pulse rx_valid.
- A consumed tx byte is lost.
REQ-027 On cs_n rise with bit counter 0, the block SHALL return to IDLE silently.
REQ-028 Multiple bytes per cs_n low SHALL be supported back-to-back without gaps.
REQ-029 sclk edges while deselected SHALL be ignored.
REQ-030 miso_oe SHALL equal the inverse of the synchronized cs_n; miso SHALL be 0 when deselected.

Reset
REQ-031 rst SHALL force:
- state to IDLE
- the synchronizers to idle values (sclk=1, cs_n=1, mosi=0)
- the shift registers and bit counter to 0, and the holding register to empty
- outputs: tx_ready=1; miso, miso_oe, rx_data, rx_valid, tx_underrun, frame_abort and busy=0.
REQ-032 Reset asserted mid-frame SHALL abort without pulsing frame_abort; after release, the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-033 Shared package spi_pkg SHALL hold the state enum, SPI_BYTE_W=8 and SPI_UNDERRUN_FILL=8'hFF.
REQ-034 One sub-module, spi_sync, SHALL implement the synchronizer chain and the sclk rise/fall and cs_n fall/rise detection.

Verification
REQ-035 Write 0xA5, then run one mode-3 byte with mosi=0x3C: miso=0xA5, rx_data=0x3C, one rx_valid pulse, tx_ready returns to 1.
REQ-036 Run a 3-byte frame (0x11, 0x22, 0x33 written in time) with mosi 0x01, 0x02, 0x03: three rx_valid pulses in order, no tx_underrun.
REQ-037 Run a byte with no write: miso=0xFF, tx_underrun pulses once, rx still received.
REQ-038 Raise cs_n after 5 bits: frame_abort pulses, rx_valid stays 0, rx_data retains its old value; the next frame works normally.
REQ-039 Write in the same cycle as LOAD: the current byte sends 0xFF with underrun, and the next byte sends the written value.
REQ-040 Assert rst mid-byte: all outputs reach reset values without waiting for clk, no frame_abort pulses, and a subsequent frame passes.
